// File: rtl/matrix_pool_engine.sv
// Max/average pooling over a row-major source matrix with a configurable window and stride.
// One output per (area + READ_LAT + 1) cycles; no backpressure, source reads are fire-and-forget.
module matrix_pool_engine #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 14,
    parameter int DIM_W    = 10,
    parameter int WIN_W    = 6,
    parameter int READ_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [ADDR_W-1:0]        src1_start_address,
    input  logic [DIM_W-1:0]         src1_row_size,
    input  logic [DIM_W-1:0]         src1_col_size,
    input  logic [WIN_W-1:0]         src2_row_size,
    input  logic [WIN_W-1:0]         src2_col_size,
    input  logic [WIN_W-1:0]         stride,
    input  logic [ADDR_W-1:0]        dest_start_address,
    output logic [ADDR_W-1:0]        src1_address,
    input  logic signed [DATA_W-1:0] src1_readdata,
    output logic [ADDR_W-1:0]        dest_address,
    output logic signed [DATA_W-1:0] dest_writedata,
    output logic                     dest_write_en,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);
    localparam int ACC_W  = DATA_W + 2 * WIN_W;
    localparam int AREA_W = 2 * WIN_W;
    localparam int SH_W   = $clog2(AREA_W);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_WRITE, S_FINISH} state_t;

    state_t                    state_q, state_d;
    logic                      mode_q, mode_d, err_q, err_d;
    logic [ADDR_W-1:0]         sbase_q, sbase_d, dbase_q, dbase_d;
    logic [DIM_W-1:0]          srows_q, srows_d, scols_q, scols_d;
    logic [WIN_W-1:0]          wrows_q, wrows_d, wcols_q, wcols_d, stride_q, stride_d;
    logic [DIM_W-1:0]          orows_q, orows_d, ocols_q, ocols_d, orow_q, orow_d, ocol_q, ocol_d;
    logic [WIN_W-1:0]          wr_q, wr_d, wc_q, wc_d;
    logic [SH_W-1:0]           shift_q, shift_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [READ_LAT-1:0]       vld_q, vld_d, first_q, first_d;
    logic [1:0]                drain_q, drain_d;

    logic [AREA_W-1:0]         area;
    logic [SH_W-1:0]           shift_calc;
    logic [DIM_W-1:0]          stride_safe;
    logic                      cfg_bad, issuing;
    logic signed [ACC_W-1:0]   rd_ext, avg_sh;
    logic [ADDR_W-1:0]         row_a, col_a, rd_addr, wr_addr;
    logic signed [DATA_W-1:0]  result;

    always_comb begin
        area        = AREA_W'(wrows_q) * AREA_W'(wcols_q);
        stride_safe = (stride_q == '0) ? DIM_W'(1) : DIM_W'(stride_q);
        shift_calc  = '0;
        for (int i = 0; i < AREA_W; i++) begin
            if (area[i]) shift_calc = SH_W'(i);
        end
        cfg_bad = (srows_q == '0) || (scols_q == '0) || (wrows_q == '0) || (wcols_q == '0) ||
                  (stride_q == '0) || (DIM_W'(wrows_q) > srows_q) || (DIM_W'(wcols_q) > scols_q) ||
                  (mode_q && ((area & (area - AREA_W'(1))) != '0));

        row_a   = ADDR_W'(orow_q) * ADDR_W'(stride_q) + ADDR_W'(wr_q);
        col_a   = ADDR_W'(ocol_q) * ADDR_W'(stride_q) + ADDR_W'(wc_q);
        rd_addr = sbase_q + row_a * ADDR_W'(scols_q) + col_a;
        wr_addr = dbase_q + ADDR_W'(orow_q) * ADDR_W'(ocols_q) + ADDR_W'(ocol_q);

        rd_ext  = {{AREA_W{src1_readdata[DATA_W-1]}}, src1_readdata};
        avg_sh  = acc_q >>> shift_q;
        result  = mode_q ? avg_sh[DATA_W-1:0] : acc_q[DATA_W-1:0];
        issuing = (state_q == S_ISSUE);
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        err_d    = err_q;
        sbase_d  = sbase_q;
        dbase_d  = dbase_q;
        srows_d  = srows_q;
        scols_d  = scols_q;
        wrows_d  = wrows_q;
        wcols_d  = wcols_q;
        stride_d = stride_q;
        orows_d  = orows_q;
        ocols_d  = ocols_q;
        orow_d   = orow_q;
        ocol_d   = ocol_q;
        wr_d     = wr_q;
        wc_d     = wc_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        drain_d  = drain_q;
        // Tag each issued address so its data is folded exactly READ_LAT cycles later.
        vld_d    = (vld_q << 1) | READ_LAT'(issuing);
        first_d  = (first_q << 1) | READ_LAT'(issuing && (wr_q == '0) && (wc_q == '0));

        if (vld_q[READ_LAT-1]) begin
            if (first_q[READ_LAT-1])  acc_d = rd_ext;
            else if (mode_q)          acc_d = acc_q + rd_ext;
            else if (rd_ext > acc_q)  acc_d = rd_ext;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    sbase_d  = src1_start_address;
                    dbase_d  = dest_start_address;
                    srows_d  = src1_row_size;
                    scols_d  = src1_col_size;
                    wrows_d  = src2_row_size;
                    wcols_d  = src2_col_size;
                    stride_d = stride;
                    err_d    = 1'b0;
                    orow_d   = '0;
                    ocol_d   = '0;
                    wr_d     = '0;
                    wc_d     = '0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    orows_d = (srows_q - DIM_W'(wrows_q)) / stride_safe + DIM_W'(1);
                    ocols_d = (scols_q - DIM_W'(wcols_q)) / stride_safe + DIM_W'(1);
                    shift_d = shift_calc;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wc_q == wcols_q - WIN_W'(1)) begin
                    wc_d = '0;
                    if (wr_q == wrows_q - WIN_W'(1)) begin
                        wr_d    = '0;
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        wr_d = wr_q + WIN_W'(1);
                    end
                end else begin
                    wc_d = wc_q + WIN_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'(READ_LAT - 1)) state_d = S_WRITE;
                else                             drain_d = drain_q + 2'd1;
            end
            S_WRITE: begin
                state_d = S_ISSUE;
                if (ocol_q == ocols_q - DIM_W'(1)) begin
                    ocol_d = '0;
                    if (orow_q == orows_q - DIM_W'(1)) state_d = S_FINISH;
                    else                               orow_d  = orow_q + DIM_W'(1);
                end else begin
                    ocol_d = ocol_q + DIM_W'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
            sbase_q  <= '0;
            dbase_q  <= '0;
            srows_q  <= '0;
            scols_q  <= '0;
            wrows_q  <= '0;
            wcols_q  <= '0;
            stride_q <= '0;
            orows_q  <= '0;
            ocols_q  <= '0;
            orow_q   <= '0;
            ocol_q   <= '0;
            wr_q     <= '0;
            wc_q     <= '0;
            shift_q  <= '0;
            acc_q    <= '0;
            vld_q    <= '0;
            first_q  <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            sbase_q  <= sbase_d;
            dbase_q  <= dbase_d;
            srows_q  <= srows_d;
            scols_q  <= scols_d;
            wrows_q  <= wrows_d;
            wcols_q  <= wcols_d;
            stride_q <= stride_d;
            orows_q  <= orows_d;
            ocols_q  <= ocols_d;
            orow_q   <= orow_d;
            ocol_q   <= ocol_d;
            wr_q     <= wr_d;
            wc_q     <= wc_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            vld_q    <= vld_d;
            first_q  <= first_d;
            drain_q  <= drain_d;
        end
    end

    assign src1_address   = issuing ? rd_addr : '0;
    assign dest_write_en  = (state_q == S_WRITE);
    assign dest_address   = dest_write_en ? wr_addr : '0;
    assign dest_writedata = dest_write_en ? result : '0;
    assign busy           = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done           = (state_q == S_FINISH);
    assign error          = err_q;
endmodule
